pipe_rr_arbiter: RTL and testbench
==================================

PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of requesters sharing the pipeline stage.
REQ-002 SHALL have parameter DATA_W, default 64; payload width, matching pipeline_data_t.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester valid.
REQ-006 SHALL have port req_data_i  input  NUM_REQ*DATA_W  per-requester payload; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port valid_o  output  1  output register holds a valid entry.
REQ-009 SHALL have port data_o  output  DATA_W  held payload.
REQ-010 SHALL have port grant_id_o  output  $clog2(NUM_REQ)  index of the requester that supplied data_o.
REQ-011 SHALL have port processed  input  1  consumer takes data_o this cycle (yumi).
REQ-012 SHALL have port grant_cnt_o  output  NUM_REQ*16  per-requester accepted-transfer counters; requester k occupies bits [k*16 +: 16].

Function
REQ-013 SHALL implement a two-state FSM: EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-014 SHALL define can_accept = EMPTY or (FULL and processed).
REQ-015 SHALL assert req_ready_o[k] combinationally only when can_accept and k is the round-robin winner among asserted req_valid_i bits.
REQ-016 SHALL search from priority pointer ptr upward with wrap-around (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1); the first valid requester wins.
REQ-017 SHALL on a transfer (req_valid_i[k] and req_ready_o[k]) load data_o and grant_id_o=k, and set valid_o=1 on the next edge: latency 1 cycle.
REQ-018 SHALL set ptr to (k+1) mod NUM_REQ after a transfer from k, and leave ptr unchanged when there is no transfer.
REQ-019 SHALL in FULL with processed and a transfer, replace the entry on the same edge; valid_o stays 1 (full throughput, one transfer per cycle).
REQ-020 SHALL in FULL with processed and no requester valid, move to EMPTY (valid_o=0).
REQ-021 SHALL in FULL without processed, keep data_o and grant_id_o stable and drive req_ready_o=0.
REQ-022 SHALL ignore processed while EMPTY.
REQ-023 SHALL leave req_valid_i with no combinational dependency on req_ready_o; requesters SHALL hold valid and data until accepted.

Reset
REQ-024 SHALL on rst=1 at a clock edge set: state EMPTY, valid_o=0, data_o=0, grant_id_o=0, ptr=0, grant_cnt_o=0.
REQ-025 SHALL during rst drive req_ready_o=0, with no transfer counted.
REQ-026 SHALL on reset mid-operation discard any held entry without it being reported as processed.

Configuration
REQ-027 SHALL provide macro PIPE_RR_ARBITER_STATS_EN.
REQ-028 SHALL with PIPE_RR_ARBITER_STATS_EN defined, increment counter k on each transfer from k, saturating at 16'hFFFF.
REQ-029 SHALL without PIPE_RR_ARBITER_STATS_EN, keep port grant_cnt_o present and tie it to 0, with no counter logic instantiated.

Verification
REQ-030 SHALL cover: reset, then req_valid_i=4'b0001 with data 64'h600d600d -> req_ready_o=4'b0001 the same cycle; next cycle valid_o=1, data_o=64'h600d600d, grant_id_o=0.
REQ-031 SHALL cover: all four requesters valid with processed=1 every cycle -> grants 0,1,2,3,0 on consecutive cycles, and valid_o continuously 1.
REQ-032 SHALL cover: FULL with processed=0 for 5 cycles while req_valid_i=4'b1111 -> req_ready_o=0 and data_o unchanged throughout.
REQ-033 SHALL cover: FULL with processed=1 and req_valid_i=0 -> valid_o=0 the next cycle; then processed=1 while EMPTY -> no state change.
REQ-034 SHALL cover: rst asserted while FULL holding 64'habcdabcd -> the next cycle shows valid_o=0, data_o=0, ptr=0, and the next grant goes to the lowest valid index.
REQ-035 SHALL cover: with PIPE_RR_ARBITER_STATS_EN, 3 transfers from requester 2 -> grant_cnt_o[47:32]=3; without the macro, grant_cnt_o=0.

Source files
------------

// File: rtl/pipe_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side handshake signals of pipe_rr_arbiter.
// "master" is the requesters plus the consumer; "slave" is the arbiter itself.
interface pipe_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      valid_o;
    logic [DATA_W-1:0]         data_o;
    logic [ID_W-1:0]           grant_id_o;
    logic                      processed;
    logic [NUM_REQ*16-1:0]     grant_cnt_o;

    modport master (
        output req_valid_i, req_data_i, processed,
        input  req_ready_o, valid_o, data_o, grant_id_o, grant_cnt_o
    );

    modport slave (
        input  req_valid_i, req_data_i, processed,
        output req_ready_o, valid_o, data_o, grant_id_o, grant_cnt_o
    );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding a single full-throughput pipeline register (EMPTY/FULL).
// Define PIPE_RR_ARBITER_STATS_EN to build the per-requester saturating transfer counters.
module pipe_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
) (
    input  logic             clk,
    input  logic             rst,
    pipe_rr_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              win_found;
    logic              can_accept;
    logic              xfer;
    logic [DATA_W-1:0] req_data [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_data[k] = bus.req_data_i[k*DATA_W +: DATA_W];
    end

    // Scan ptr, ptr+1, ... with wrap-around; the first valid requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!win_found && bus.req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign can_accept = (state == EMPTY) || bus.processed;
    assign xfer       = can_accept && win_found && !rst;
    assign next_ptr   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign bus.valid_o = (state == FULL);

    always_comb begin
        bus.req_ready_o = '0;
        if (xfer) begin
            bus.req_ready_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload register is reset too, so an entry discarded by reset never reappears.
            state          <= EMPTY;
            ptr            <= '0;
            bus.data_o     <= '0;
            bus.grant_id_o <= '0;
        end else if (xfer) begin
            // NOTE: sequential state uses <= so every update here sees the pre-edge values.
            state          <= FULL;
            ptr            <= next_ptr;
            bus.data_o     <= req_data[win_idx];
            bus.grant_id_o <= win_idx;
        end else if ((state == FULL) && bus.processed) begin
            state <= EMPTY;
        end
    end

`ifdef PIPE_RR_ARBITER_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        logic [15:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (xfer && (win_idx == ID_W'(k)) && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign bus.grant_cnt_o[k*16 +: 16] = cnt;
    end
`else
    assign bus.grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter: directed scenarios then random traffic,
// all compared against a queue-free behavioural round-robin model.
module tb_pipe_rr_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    pipe_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Requester / consumer stimulus
    logic [N-1:0] v;
    logic [W-1:0] dat [N];
    logic         proc;
    logic [N-1:0] last_rdy;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;
    int           m_cnt [N];
    bit           after_rst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = valid requester at the smallest forward distance from ptr.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        int best   = -1;
        int best_d = N;
        for (int k = 0; k < N; k++) begin
            if (req[k] && (((k - ptr + N) % N) < best_d)) begin
                best_d = (k - ptr + N) % N;
                best   = k;
            end
        end
        return best;
    endfunction

    task automatic step(input string tag);
        logic [N-1:0]  exp_rdy;
        logic [63:0]   exp_cnt;
        int            w;
        bus.req_valid_i = v;
        for (int k = 0; k < N; k++) bus.req_data_i[k*W +: W] = dat[k];
        bus.processed = proc;
        #1;
        exp_rdy = '0;
        w = rr_pick(v, m_ptr);
        if (!rst && (!m_valid || proc) && (w >= 0)) exp_rdy[w] = 1'b1;
        check({tag, "/ready"}, 64'(bus.req_ready_o), 64'(exp_rdy));
        last_rdy = exp_rdy;

        @(posedge clk);
        if (rst) begin
            m_valid   = 1'b0;
            m_data    = '0;
            m_id      = 0;
            m_ptr     = 0;
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (exp_rdy != '0) begin
                m_valid = 1'b1;
                m_data  = dat[w];
                m_id    = w;
                m_ptr   = (w + 1) % N;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end else if (m_valid && proc) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, "/valid"}, 64'(bus.valid_o), 64'(m_valid));
        if (m_valid || after_rst) begin
            check({tag, "/data"}, bus.data_o, m_data);
            check({tag, "/id"}, 64'(bus.grant_id_o), 64'(m_id));
        end
        exp_cnt = '0;
`ifdef PIPE_RR_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) exp_cnt[k*16 +: 16] = 16'(m_cnt[k]);
`endif
        check({tag, "/cnt"}, bus.grant_cnt_o, exp_cnt);

        // An accepted requester presents a fresh payload next time it is valid.
        for (int k = 0; k < N; k++) if (exp_rdy[k]) dat[k] = {$urandom, $urandom};
    endtask

    initial begin
        rst      = 1'b1;
        v        = '0;
        proc     = 1'b0;
        last_rdy = '0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_id     = 0;
        m_ptr    = 0;
        after_rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            dat[k]   = '0;
            m_cnt[k] = 0;
        end

        // Reset state
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Single request: same-cycle ready, one-cycle latency to the register
        v      = 4'b0001;
        dat[0] = 64'h600d600d;
        step("single");
        check("single/data_const", bus.data_o, 64'h600d600d);
        v = 4'b0000;

        // Full throughput rotation 0,1,2,3,0 from a fresh pointer
        rst = 1'b1;
        step("rr_reset");
        rst  = 1'b0;
        v    = 4'b1111;
        proc = 1'b1;
        for (int k = 0; k < N; k++) dat[k] = 64'h1000 + 64'(k);
        for (int i = 0; i < 5; i++) begin
            step("rr");
            check("rr/grant_seq", 64'(bus.grant_id_o), 64'(i % N));
            check("rr/valid_held", 64'(bus.valid_o), 64'd1);
        end

        // Stall: consumer not taking, all requesters waiting
        proc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("stall");
            check("stall/ready_zero", 64'(bus.req_ready_o), 64'd0);
        end

        // Drain to EMPTY, then processed while EMPTY changes nothing
        v    = 4'b0000;
        proc = 1'b1;
        step("drain");
        step("empty_proc");
        check("empty_proc/valid", 64'(bus.valid_o), 64'd0);

        // Reset while FULL with ptr away from 0
        proc   = 1'b0;
        v      = 4'b0010;
        dat[1] = 64'habcdabcd;
        step("pre_rst");
        check("pre_rst/data", bus.data_o, 64'habcdabcd);
        rst = 1'b1;
        v   = 4'b1010;
        step("mid_rst");
        rst = 1'b0;
        step("post_rst");
        check("post_rst/lowest", 64'(last_rdy), 64'(4'b0010));
        v = 4'b0000;

        // Three transfers from requester 2 after reset
        rst = 1'b1;
        step("cnt_reset");
        rst  = 1'b0;
        proc = 1'b1;
        v    = 4'b0100;
        for (int i = 0; i < 3; i++) step("cnt2");
`ifdef PIPE_RR_ARBITER_STATS_EN
        check("cnt2/value", 64'(bus.grant_cnt_o[47:32]), 64'd3);
`else
        check("cnt2/value", 64'(bus.grant_cnt_o[47:32]), 64'd0);
`endif
        v = 4'b0000;

        // Random traffic; requesters hold valid and data until accepted
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!v[k] && ($urandom_range(0, 2) == 0)) begin
                    v[k]   = 1'b1;
                    dat[k] = {$urandom, $urandom};
                end
            end
            proc = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 63) == 0);
            step("rand");
            for (int k = 0; k < N; k++) begin
                if (last_rdy[k] && ($urandom_range(0, 1) == 0)) v[k] = 1'b0;
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
